seg7_result_display: RTL

Output-side counterpart to the switch/button operand loader on the FPGA ALU test harness. It takes 32-bit results and the zero flag through a single-cycle load strobe and presents them on an 8-digit multiplexed, common-anode seven-segment display as hexadecimal. It also performs time-multiplexed digit scanning, tear-free frame updates and leading-zero blanking, and it reports when a loaded value becomes visible.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_hex_decoder.sv | 13 +
 rtl/seg7_result_display.sv | 110 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the seven-segment result display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
   localparam logic [6:0]  SEG_OFF    = 7'h7F;
   localparam logic [7:0]  AN_OFF     = 8'hFF;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = hex_to_seg(nibble);
   end

endmodule

// File: rtl/seg7_result_display.sv
// Loads 32-bit results plus zero flag and scans them as hex onto an 8-digit
// common-anode display; new values swap in only at frame boundaries.
module seg7_result_display
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load,
   input  logic [31:0] value,
   input  logic        flag,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        shown
);

   localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

   logic [DIV_W-1:0]   div;
   logic [DIGIT_W-1:0] digit;
   logic [31:0]        cap_val;
   logic               cap_flag;
   logic               pending;
   logic [31:0]        disp_val;
   logic               disp_flag;

   logic               div_wrap;
   logic               frame_end;
   logic               transfer;
   logic [31:0]        shifted;
   logic [3:0]         nibble;
   logic [6:0]         nib_seg;
   logic               blank;

   assign div_wrap  = (div == DIV_LAST);
   assign frame_end = enable && div_wrap && (digit == DIGIT_LAST);
   assign transfer  = frame_end && pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div   <= '0;
         digit <= '0;
      end else if (!enable) begin
         div   <= '0;
         digit <= '0;
      end else if (div_wrap) begin
         div   <= '0;
         digit <= digit + DIGIT_W'(1);
      end else begin
         div   <= div + DIV_W'(1);
      end
   end

   // A load coinciding with a transfer is captured and stays pending for the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_val   <= '0;
         cap_flag  <= 1'b0;
         pending   <= 1'b0;
         disp_val  <= '0;
         disp_flag <= 1'b0;
         shown     <= 1'b0;
      end else begin
         if (load) begin
            cap_val  <= value;
            cap_flag <= flag;
         end
         if (transfer) begin
            disp_val  <= cap_val;
            disp_flag <= cap_flag;
         end
         pending <= load || (pending && !transfer);
         shown   <= transfer;
      end
   end

   always_comb begin
      shifted = disp_val >> {digit, 2'b00};
      nibble  = shifted[3:0];
      blank   = BLANK_LZ && (digit != '0) && (shifted == 32'd0);
   end

   seg7_hex_decoder u_dec (
      .nibble (nibble),
      .seg    (nib_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else if (!enable || blank) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         an  <= ~(8'd1 << digit);
         seg <= nib_seg;
         dp  <= !((digit == '0) && disp_flag);
      end
   end

endmodule
